// File: rtl/legv8_decode_stage.sv
// legv8_decode_stage
// Decode/operand stage feeding the 4-bit-opcode ALU. Decodes one LEGv8
// instruction per accepted handshake and reads two operands from a 32x32
// register file that has a write-through bypass. The decoded bundle sits in
// a single-entry pipeline register toward execute. While that entry is
// stalled, write-backs refresh any held register-sourced operand.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid && !ready.
// in_ready = !out_valid || out_ready, so a drain and an accept can happen on
// the same edge with no bubble. flush discards the held entry and any
// same-edge accept. reset takes priority over everything else.
module legv8_decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_op_a,
    output logic [31:0] out_op_b,
    output logic [3:0]  out_alu_op,
    output logic [31:0] out_store_data,
    output logic [31:0] out_br_off,
    output logic [4:0]  out_rd,
    output logic        out_reg_write,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_branch,
    output logic        out_illegal
);

    // Opcode encodings (instr[31:21], CBZ uses instr[31:24])
    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_EOR  = 11'b11001010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    localparam logic [3:0]  ALU_ADD  = 4'b0010;
    localparam logic [3:0]  ALU_SUB  = 4'b1010;
    localparam logic [3:0]  ALU_AND  = 4'b0110;
    localparam logic [3:0]  ALU_ORR  = 4'b0100;
    localparam logic [3:0]  ALU_EOR  = 4'b1001;
    localparam logic [3:0]  ALU_PASS = 4'b0111;

    localparam logic [4:0]  XZR      = 5'd31;

    // Register file storage
    logic [31:0] regs [0:31];

    // Instruction fields
    logic [4:0]  f_rm;
    logic [4:0]  f_rn;
    logic [4:0]  f_rt;
    logic [10:0] f_opc;

    // Register read values after X31 and write-through handling
    logic [31:0] rn_val;
    logic [31:0] rm_val;
    logic [31:0] rt_val;

    // Decoded bundle before it enters the pipeline register
    logic [31:0] d_op_a;
    logic [31:0] d_op_b;
    logic [3:0]  d_alu_op;
    logic [31:0] d_store;
    logic [31:0] d_br_off;
    logic [4:0]  d_rd;
    logic        d_reg_write;
    logic        d_mem_read;
    logic        d_mem_write;
    logic        d_branch;
    logic        d_illegal;
    logic [4:0]  d_src_a;
    logic [4:0]  d_src_b;
    logic [4:0]  d_src_s;
    logic        d_a_is_reg;
    logic        d_b_is_reg;
    logic        d_s_is_reg;

    // Source tracking of the held bundle, used for refresh while stalled
    logic [4:0]  h_src_a;
    logic [4:0]  h_src_b;
    logic [4:0]  h_src_s;
    logic        h_a_is_reg;
    logic        h_b_is_reg;
    logic        h_s_is_reg;

    logic        accept;
    logic        stalled;
    logic        wb_live;
    logic        instr_unused;

    assign f_rm  = in_instr[20:16];
    assign f_rn  = in_instr[9:5];
    assign f_rt  = in_instr[4:0];
    assign f_opc = in_instr[31:21];

    // The op2 field of LDUR/STUR is not decoded.
    assign instr_unused = ^in_instr[11:10];

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign stalled  = out_valid && !out_ready;
    assign wb_live  = wb_en && (wb_addr != XZR);

    // Read ports: X31 reads zero; a same-cycle write to the index is forwarded
    always_comb begin
        rn_val = regs[f_rn];
        rm_val = regs[f_rm];
        rt_val = regs[f_rt];
        if (wb_live && (wb_addr == f_rn)) rn_val = wb_data;
        if (wb_live && (wb_addr == f_rm)) rm_val = wb_data;
        if (wb_live && (wb_addr == f_rt)) rt_val = wb_data;
        if (f_rn == XZR) rn_val = '0;
        if (f_rm == XZR) rm_val = '0;
        if (f_rt == XZR) rt_val = '0;
    end

    // Instruction decode into the next bundle
    always_comb begin
        d_op_a      = '0;
        d_op_b      = '0;
        d_alu_op    = 4'b0000;
        d_store     = '0;
        d_br_off    = '0;
        d_rd        = '0;
        d_reg_write = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        d_branch    = 1'b0;
        d_illegal   = 1'b0;
        d_src_a     = '0;
        d_src_b     = '0;
        d_src_s     = '0;
        d_a_is_reg  = 1'b0;
        d_b_is_reg  = 1'b0;
        d_s_is_reg  = 1'b0;

        if (in_instr[31:24] == OPC_CBZ) begin
            // Compare Rt against zero; offset is the word offset scaled to bytes
            d_alu_op   = ALU_PASS;
            d_op_a     = rt_val;
            d_op_b     = '0;
            d_branch   = 1'b1;
            d_br_off   = {{11{in_instr[23]}}, in_instr[23:5], 2'b00};
            d_rd       = f_rt;
            d_src_a    = f_rt;
            d_a_is_reg = 1'b1;
        end else begin
            case (f_opc)
                OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_EOR: begin
                    d_op_a      = rn_val;
                    d_op_b      = rm_val;
                    d_rd        = f_rt;
                    d_reg_write = 1'b1;
                    d_src_a     = f_rn;
                    d_src_b     = f_rm;
                    d_a_is_reg  = 1'b1;
                    d_b_is_reg  = 1'b1;
                    case (f_opc)
                        OPC_SUB: d_alu_op = ALU_SUB;
                        OPC_AND: d_alu_op = ALU_AND;
                        OPC_ORR: d_alu_op = ALU_ORR;
                        OPC_EOR: d_alu_op = ALU_EOR;
                        default: d_alu_op = ALU_ADD;
                    endcase
                end
                OPC_LDUR: begin
                    d_alu_op    = ALU_ADD;
                    d_op_a      = rn_val;
                    d_op_b      = {{23{in_instr[20]}}, in_instr[20:12]};
                    d_rd        = f_rt;
                    d_mem_read  = 1'b1;
                    d_reg_write = 1'b1;
                    d_src_a     = f_rn;
                    d_a_is_reg  = 1'b1;
                end
                OPC_STUR: begin
                    d_alu_op    = ALU_ADD;
                    d_op_a      = rn_val;
                    d_op_b      = {{23{in_instr[20]}}, in_instr[20:12]};
                    d_store     = rt_val;
                    d_rd        = f_rt;
                    d_mem_write = 1'b1;
                    d_src_a     = f_rn;
                    d_src_s     = f_rt;
                    d_a_is_reg  = 1'b1;
                    d_s_is_reg  = 1'b1;
                end
                default: begin
                    d_illegal = 1'b1;
                end
            endcase
        end
    end

    // Register file write port; index 31 is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Pipeline register: reset > flush > accept/drain > refresh while stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid      <= 1'b0;
            out_op_a       <= '0;
            out_op_b       <= '0;
            out_alu_op     <= '0;
            out_store_data <= '0;
            out_br_off     <= '0;
            out_rd         <= '0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_branch     <= 1'b0;
            out_illegal    <= 1'b0;
            h_src_a        <= '0;
            h_src_b        <= '0;
            h_src_s        <= '0;
            h_a_is_reg     <= 1'b0;
            h_b_is_reg     <= 1'b0;
            h_s_is_reg     <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid      <= 1'b1;
            out_op_a       <= d_op_a;
            out_op_b       <= d_op_b;
            out_alu_op     <= d_alu_op;
            out_store_data <= d_store;
            out_br_off     <= d_br_off;
            out_rd         <= d_rd;
            out_reg_write  <= d_reg_write;
            out_mem_read   <= d_mem_read;
            out_mem_write  <= d_mem_write;
            out_branch     <= d_branch;
            out_illegal    <= d_illegal;
            h_src_a        <= d_src_a;
            h_src_b        <= d_src_b;
            h_src_s        <= d_src_s;
            h_a_is_reg     <= d_a_is_reg;
            h_b_is_reg     <= d_b_is_reg;
            h_s_is_reg     <= d_s_is_reg;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else if (stalled && wb_live) begin
            // A held operand tracks later writes to its source register
            if (h_a_is_reg && (h_src_a == wb_addr)) out_op_a       <= wb_data;
            if (h_b_is_reg && (h_src_b == wb_addr)) out_op_b       <= wb_data;
            if (h_s_is_reg && (h_src_s == wb_addr)) out_store_data <= wb_data;
        end
    end

endmodule

// File: tb/tb_legv8_decode_stage.sv
// Testbench for legv8_decode_stage: directed scenarios followed by random
// traffic. The reference model treats a register-sourced operand as the
// register file content at the moment the bundle is handed to execute.
module tb_legv8_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic [3:0]  out_alu_op;
  logic [31:0] out_store_data;
  logic [31:0] out_br_off;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_branch;
  logic        out_illegal;

  legv8_decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_alu_op(out_alu_op),
    .out_store_data(out_store_data), .out_br_off(out_br_off), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_branch(out_branch),
    .out_illegal(out_illegal)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];        // accepted instruction words awaiting hand-off
  logic [31:0] m_regs[32];      // architectural register file of the model
  logic        exp_ready = 1'b1;

  typedef struct packed {
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] store;
    logic [31:0] br;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        brf;
    logic        ill;
    logic        care_ops;
    logic        care_store;
    logic        care_br;
    logic        care_rd;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rv(input logic [4:0] idx);
    return (idx == 5'd31) ? 32'd0 : m_regs[idx];
  endfunction

  // Reference decode straight from the instruction-set rules
  function automatic exp_t ref_model(input logic [31:0] w);
    exp_t        e;
    int          imm;
    int          off;
    logic [10:0] op;
    e   = '0;
    op  = w[31:21];
    imm = w[20] ? int'(w[20:12]) - 512 : int'(w[20:12]);
    off = w[23] ? int'(w[23:5]) - 524288 : int'(w[23:5]);
    if (w[31:24] == 8'hB4) begin
      e.alu = 4'b0111; e.op_a = rv(w[4:0]); e.op_b = 32'd0; e.brf = 1'b1;
      e.br = 32'(off * 4); e.care_ops = 1'b1; e.care_br = 1'b1;
    end else begin
      case (op)
        11'b10001011000, 11'b11001011000, 11'b10001010000,
        11'b10101010000, 11'b11001010000: begin
          case (op)
            11'b10001011000: e.alu = 4'b0010;
            11'b11001011000: e.alu = 4'b1010;
            11'b10001010000: e.alu = 4'b0110;
            11'b10101010000: e.alu = 4'b0100;
            default:         e.alu = 4'b1001;
          endcase
          e.op_a = rv(w[9:5]); e.op_b = rv(w[20:16]); e.rw = 1'b1;
          e.rd = w[4:0]; e.care_ops = 1'b1; e.care_rd = 1'b1;
        end
        11'b11111000010: begin
          e.alu = 4'b0010; e.op_a = rv(w[9:5]); e.op_b = 32'(imm);
          e.mr = 1'b1; e.rw = 1'b1; e.rd = w[4:0];
          e.care_ops = 1'b1; e.care_rd = 1'b1;
        end
        11'b11111000000: begin
          e.alu = 4'b0010; e.op_a = rv(w[9:5]); e.op_b = 32'(imm);
          e.mw = 1'b1; e.store = rv(w[4:0]);
          e.care_ops = 1'b1; e.care_store = 1'b1;
        end
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  // Monitor: compares presented bundle with the head, pops on hand-off
  always @(negedge clk) begin
    exp_t e;
    exp_ready = (exp_q.size() == 0) || out_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = ref_model(exp_q[0]);
      chk("alu_op", 32'(out_alu_op), 32'(e.alu));
      chk("reg_write", 32'(out_reg_write), 32'(e.rw));
      chk("mem_read", 32'(out_mem_read), 32'(e.mr));
      chk("mem_write", 32'(out_mem_write), 32'(e.mw));
      chk("branch", 32'(out_branch), 32'(e.brf));
      chk("illegal", 32'(out_illegal), 32'(e.ill));
      if (e.care_ops) begin
        chk("op_a", out_op_a, e.op_a);
        chk("op_b", out_op_b, e.op_b);
      end
      if (e.care_store) chk("store_data", out_store_data, e.store);
      if (e.care_br) chk("br_off", out_br_off, e.br);
      if (e.care_rd) chk("rd", 32'(out_rd), 32'(e.rd));
      if (!reset && !flush && out_ready) void'(exp_q.pop_front());
    end
  end

  // Model: acceptance and register-file update at each rising edge
  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      if (flush) exp_q.delete();
      else if (in_valid && exp_ready) exp_q.push_back(in_instr);
      if (wb_en && wb_addr != 5'd31) m_regs[wb_addr] = wb_data;
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [31:0] ins, input logic ordy,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic fl, input logic rst);
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    wb_en     = we;
    wb_addr   = wa;
    wb_data   = wd;
    flush     = fl;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, ordy, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    step(1'b0, 32'd0, 1'b1, 1'b1, wa, wd, 1'b0, 1'b0);
  endtask

  task automatic issue(input logic [31:0] ins);
    step(1'b1, ins, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [4:0] rand_reg();
    return ($urandom_range(0, 9) == 9) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom();
    w[20:16] = rand_reg();
    w[9:5]   = rand_reg();
    w[4:0]   = rand_reg();
    case ($urandom_range(0, 8))
      0: w[31:21] = 11'b10001011000;
      1: w[31:21] = 11'b11001011000;
      2: w[31:21] = 11'b10001010000;
      3: w[31:21] = 11'b10101010000;
      4: w[31:21] = 11'b11001010000;
      5: w[31:21] = 11'b11111000010;
      6: w[31:21] = 11'b11111000000;
      7: w[31:24] = 8'hB4;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    // reset
    step(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_op_a", out_op_a, 32'd0);
    chk("rst_op_b", out_op_b, 32'd0);
    chk("rst_alu_op", 32'(out_alu_op), 32'd0);
    chk("rst_ctrl", 32'({out_reg_write, out_mem_read, out_mem_write, out_branch, out_illegal}), 32'd0);
    idle(1'b1);

    // ADD X3,X1,X2
    wr(5'd1, 32'd15);
    wr(5'd2, 32'd15);
    issue(32'h8B020023);
    chk("add_op_a", out_op_a, 32'd15);
    chk("add_op_b", out_op_b, 32'd15);
    chk("add_alu_op", 32'(out_alu_op), 32'h2);
    chk("add_rd", 32'(out_rd), 32'd3);

    // LDUR X4,[X1,#-8]
    issue(32'hF85F8024);
    chk("ldur_op_b", out_op_b, 32'hFFFFFFF8);
    chk("ldur_mem_read", 32'(out_mem_read), 32'd1);

    // CBZ X1,#-1
    issue(32'hB4FFFFE1);
    chk("cbz_op_a", out_op_a, 32'd15);
    chk("cbz_br_off", out_br_off, 32'hFFFFFFFC);
    chk("cbz_alu_op", 32'(out_alu_op), 32'h7);

    // ORR X6,X5,X31 with same-cycle write of X5
    step(1'b1, 32'hAA1F00A6, 1'b1, 1'b1, 5'd5, 32'd7, 1'b0, 1'b0);
    chk("byp_op_a", out_op_a, 32'd7);
    chk("byp_op_b", out_op_b, 32'd0);
    chk("byp_alu_op", 32'(out_alu_op), 32'h4);

    // write X31 then ADD X10,X31,X31
    wr(5'd31, 32'h1234);
    issue(32'h8B1F03EA);
    chk("x31_op_a", out_op_a, 32'd0);

    // SUB X7,X1,X2 stalled, X2 rewritten while held
    issue(32'hCB020027);
    step(1'b0, 32'd0, 1'b0, 1'b1, 5'd2, 32'd10, 1'b0, 1'b0);
    chk("refresh_op_b", out_op_b, 32'd10);
    chk("refresh_alu_op", 32'(out_alu_op), 32'hA);
    idle(1'b1);

    // flush on an accepting cycle; the write-back still lands
    step(1'b1, 32'h8B020029, 1'b1, 1'b1, 5'd8, 32'd99, 1'b1, 1'b0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    issue(32'h8B1F010B);
    chk("flush_wb_op_a", out_op_a, 32'd99);

    // illegal word
    issue(32'h00000000);
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    chk("illegal_ctrl", 32'({out_alu_op, out_reg_write, out_mem_read, out_mem_write, out_branch}), 32'd0);

    // reset during a stall
    issue(32'h8B020023);
    step(1'b1, 32'hCB020027, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 32'hCB020027, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_op_a", out_op_a, 32'd0);
    issue(32'h8B020023);
    chk("midrst_regs_cleared", out_op_a, 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), rand_instr(), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), rand_reg(), $urandom(),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 99) == 0));
    end

    // drain
    for (int n = 0; n < 4; n++) idle(1'b1);
    chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
